// File: rtl/xperm_seq_fu.sv
// Sequential Zbkx xperm4/xperm8 unit: resolves LANES table lookups per cycle and
// holds the result on a valid/ready output port until it is consumed.
module xperm_seq_fu #(
  parameter int XLEN  = 32,
  parameter int LANES = 2
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            valid_i,
  output logic            ready_o,
  input  logic            mode_i,
  input  logic [XLEN-1:0] rs1_i,
  input  logic [XLEN-1:0] rs2_i,
  input  logic            flush_i,
  output logic            valid_o,
  input  logic            ready_i,
  output logic [XLEN-1:0] rd_o
);

  localparam int N4 = XLEN / 4;
  localparam int N8 = XLEN / 8;
  localparam int CW = $clog2(N4);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_e;

  state_e          state_q;
  logic [CW-1:0]   cnt_q;
  logic            mode_q;
  logic [XLEN-1:0] rs1_q;
  logic [XLEN-1:0] rs2_q;
  logic [XLEN-1:0] rd_q;
  logic [XLEN-1:0] rd_d;
  logic            last_d;

  // Lookups scan every legal entry, so any index >= N yields zero for free.
  function automatic logic [3:0] lut4(input logic [XLEN-1:0] tbl, input logic [3:0] idx);
    lut4 = '0;
    for (int j = 0; j < N4; j++)
      if (int'(idx) == j) lut4 = tbl[4*j +: 4];
  endfunction

  function automatic logic [7:0] lut8(input logic [XLEN-1:0] tbl, input logic [7:0] idx);
    lut8 = '0;
    for (int j = 0; j < N8; j++)
      if (int'(idx) == j) lut8 = tbl[8*j +: 8];
  endfunction

  always_comb begin
    rd_d = rd_q;
    if (mode_q) begin
      for (int i = 0; i < N8; i++)
        if (i >= int'(cnt_q) && i < int'(cnt_q) + LANES)
          rd_d[8*i +: 8] = lut8(rs1_q, rs2_q[8*i +: 8]);
    end else begin
      for (int i = 0; i < N4; i++)
        if (i >= int'(cnt_q) && i < int'(cnt_q) + LANES)
          rd_d[4*i +: 4] = lut4(rs1_q, rs2_q[4*i +: 4]);
    end
    last_d = (int'(cnt_q) + LANES) >= (mode_q ? N8 : N4);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      rd_q    <= '0;
    end else if (flush_i) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (valid_i) begin
            rs1_q   <= rs1_i;
            rs2_q   <= rs2_i;
            mode_q  <= mode_i;
            rd_q    <= '0;
            cnt_q   <= '0;
            state_q <= BUSY;
          end
        end
        BUSY: begin
          rd_q <= rd_d;
          // Counter is cleared on the final iteration instead of stepping past N.
          if (last_d) begin
            cnt_q   <= '0;
            state_q <= DONE;
          end else begin
            cnt_q <= cnt_q + CW'(LANES);
          end
        end
        DONE: begin
          if (ready_i) state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign ready_o = (state_q == IDLE);
  assign valid_o = (state_q == DONE);
  assign rd_o    = rd_q;

endmodule

// File: tb/tb_xperm_seq_fu.sv
// Directed bench for xperm_seq_fu: three instances (RV32/L2, RV32/L1, RV64/L4)
// share control inputs; each operation targets one instance.
module tb_xperm_seq_fu;

  logic        clk = 1'b0;
  logic        rst, flush, mode, ready;
  logic [63:0] rs1, rs2;
  logic        valid_a, valid_b, valid_c;
  logic        rdy_a, rdy_b, rdy_c;
  logic        vo_a, vo_b, vo_c;
  logic [31:0] rd_a, rd_b;
  logic [63:0] rd_c;
  int          total = 0;
  int          bad   = 0;

  always #5 clk = ~clk;

  xperm_seq_fu #(.XLEN(32), .LANES(2)) u_a (
    .clk_i(clk), .rst_i(rst), .valid_i(valid_a), .ready_o(rdy_a), .mode_i(mode),
    .rs1_i(rs1[31:0]), .rs2_i(rs2[31:0]), .flush_i(flush), .valid_o(vo_a),
    .ready_i(ready), .rd_o(rd_a));

  xperm_seq_fu #(.XLEN(32), .LANES(1)) u_b (
    .clk_i(clk), .rst_i(rst), .valid_i(valid_b), .ready_o(rdy_b), .mode_i(mode),
    .rs1_i(rs1[31:0]), .rs2_i(rs2[31:0]), .flush_i(flush), .valid_o(vo_b),
    .ready_i(ready), .rd_o(rd_b));

  xperm_seq_fu #(.XLEN(64), .LANES(4)) u_c (
    .clk_i(clk), .rst_i(rst), .valid_i(valid_c), .ready_o(rdy_c), .mode_i(mode),
    .rs1_i(rs1), .rs2_i(rs2), .flush_i(flush), .valid_o(vo_c),
    .ready_i(ready), .rd_o(rd_c));

  task automatic chk_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic get_ready(input int s);
    return (s == 0) ? rdy_a : (s == 1) ? rdy_b : rdy_c;
  endfunction

  function automatic logic get_valid(input int s);
    return (s == 0) ? vo_a : (s == 1) ? vo_b : vo_c;
  endfunction

  function automatic logic [63:0] get_rd(input int s);
    return (s == 0) ? {32'h0, rd_a} : (s == 1) ? {32'h0, rd_b} : rd_c;
  endfunction

  task automatic set_valid(input int s, input logic v);
    valid_a = (s == 0) ? v : 1'b0;
    valid_b = (s == 1) ? v : 1'b0;
    valid_c = (s == 2) ? v : 1'b0;
  endtask

  // Issue one op, scramble operands right after accept, measure latency and result.
  task automatic run_op(input int s, input logic md, input logic [63:0] a, input logic [63:0] b,
                        input logic [63:0] exp_rd, input int exp_lat, input string tag);
    int lat;
    logic seen;
    @(negedge clk);
    chk_eq({tag, "_rdy"}, 64'(get_ready(s)), 64'd1);
    mode = md; rs1 = a; rs2 = b;
    set_valid(s, 1'b1);
    @(posedge clk); #1;
    set_valid(s, 1'b0);
    mode = ~md; rs1 = a ^ 64'h5A5A_C3C3_0F0F_9696; rs2 = ~b;
    lat = 0; seen = 1'b0;
    while (!seen && lat < 40) begin
      @(posedge clk); #1;
      lat++;
      seen = get_valid(s);
    end
    chk_eq({tag, "_lat"}, 64'(lat), 64'(exp_lat));
    chk_eq({tag, "_rd"}, get_rd(s), exp_rd);
    if (ready) begin
      @(posedge clk); #1;
      chk_eq({tag, "_rel_rdy"}, 64'(get_ready(s)), 64'd1);
      chk_eq({tag, "_rel_vld"}, 64'(get_valid(s)), 64'd0);
    end
  endtask

  initial begin
    rst = 1'b1; flush = 1'b0; mode = 1'b0; ready = 1'b1;
    rs1 = '0; rs2 = '0;
    set_valid(0, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    chk_eq("rst_rdy_a", 64'(rdy_a), 64'd1);
    chk_eq("rst_vld_a", 64'(vo_a), 64'd0);
    chk_eq("rst_rd_a", {32'h0, rd_a}, 64'd0);
    chk_eq("rst_rdy_c", 64'(rdy_c), 64'd1);
    chk_eq("rst_rd_c", rd_c, 64'd0);
    @(negedge clk); rst = 1'b0;

    run_op(0, 1'b0, 64'hFEDCBA98, 64'h76543210, 64'hFEDCBA98, 4, "id4_l2");
    run_op(1, 1'b0, 64'hFEDCBA98, 64'h76543210, 64'hFEDCBA98, 8, "id4_l1");
    run_op(0, 1'b0, 64'hFEDCBA98, 64'h01234567, 64'h89ABCDEF, 4, "rev4");
    run_op(0, 1'b0, 64'hFEDCBA98, 64'h000000F8, 64'h88888800, 4, "oor4");
    run_op(0, 1'b1, 64'h44332211, 64'h00010203, 64'h11223344, 2, "rev8");
    run_op(0, 1'b1, 64'h44332211, 64'h04000100, 64'h00112211, 2, "oor8");
    run_op(2, 1'b0, 64'hFEDCBA9876543210, 64'h0123456789ABCDEF, 64'h0123456789ABCDEF, 4, "x64_4");
    run_op(2, 1'b1, 64'h8877665544332211, 64'h0001020304050607, 64'h1122334455667788, 2, "x64_8");
    run_op(2, 1'b1, 64'h8877665544332211, 64'h0000000000000008, 64'h1111111111111100, 2, "x64_oor");

    // Backpressure: result and handshake must hold while the consumer stalls.
    ready = 1'b0;
    run_op(0, 1'b0, 64'hFEDCBA98, 64'h01234567, 64'h89ABCDEF, 4, "bp");
    for (int k = 0; k < 5; k++) begin
      @(posedge clk); #1;
      chk_eq("bp_hold_rd", {32'h0, rd_a}, 64'h89ABCDEF);
      chk_eq("bp_hold_vld", 64'(vo_a), 64'd1);
      chk_eq("bp_hold_rdy", 64'(rdy_a), 64'd0);
    end
    @(negedge clk); ready = 1'b1;
    @(posedge clk); #1;
    chk_eq("bp_rel_rdy", 64'(rdy_a), 64'd1);
    chk_eq("bp_rel_vld", 64'(vo_a), 64'd0);

    // Reset during the second BUSY cycle.
    @(negedge clk);
    mode = 1'b0; rs1 = 64'hFEDCBA98; rs2 = 64'h01234567; set_valid(0, 1'b1);
    @(posedge clk); #1; set_valid(0, 1'b0);
    @(posedge clk);
    @(negedge clk); rst = 1'b1;
    @(posedge clk); #1;
    chk_eq("ab_rst_vld", 64'(vo_a), 64'd0);
    chk_eq("ab_rst_rdy", 64'(rdy_a), 64'd1);
    chk_eq("ab_rst_rd", {32'h0, rd_a}, 64'd0);
    @(negedge clk); rst = 1'b0;
    run_op(0, 1'b1, 64'h44332211, 64'h00010203, 64'h11223344, 2, "post_rst");

    // Flush during BUSY.
    @(negedge clk);
    mode = 1'b0; rs1 = 64'hFEDCBA98; rs2 = 64'h76543210; set_valid(0, 1'b1);
    @(posedge clk); #1; set_valid(0, 1'b0);
    @(negedge clk); flush = 1'b1;
    @(posedge clk); #1;
    chk_eq("fl_busy_rdy", 64'(rdy_a), 64'd1);
    @(negedge clk); flush = 1'b0;
    for (int k = 0; k < 6; k++) begin
      @(posedge clk); #1;
      chk_eq("fl_busy_vld", 64'(vo_a), 64'd0);
    end
    run_op(0, 1'b0, 64'hFEDCBA98, 64'h000000F8, 64'h88888800, 4, "post_fl");

    // Flush together with ready_i in DONE.
    ready = 1'b0;
    run_op(0, 1'b0, 64'hFEDCBA98, 64'h76543210, 64'hFEDCBA98, 4, "fl_done");
    @(negedge clk); flush = 1'b1; ready = 1'b1;
    @(posedge clk); #1;
    chk_eq("fl_done_vld", 64'(vo_a), 64'd0);
    chk_eq("fl_done_rdy", 64'(rdy_a), 64'd1);

    // Flush beats valid in IDLE: no accept may happen.
    @(negedge clk); set_valid(0, 1'b1);
    @(posedge clk); #1;
    chk_eq("fl_idle_rdy", 64'(rdy_a), 64'd1);
    @(negedge clk); flush = 1'b0; set_valid(0, 1'b0);
    for (int k = 0; k < 5; k++) begin
      @(posedge clk); #1;
      chk_eq("fl_idle_vld", 64'(vo_a), 64'd0);
    end
    run_op(0, 1'b0, 64'hFEDCBA98, 64'h01234567, 64'h89ABCDEF, 4, "post_fl2");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
